vo_frame_scheduler: RTL and testbench
=====================================

# vo_frame_scheduler

Front-end sequencer for the visual-odometry chip. It accepts a camera pixel+depth stream with a valid/ready handshake and launches whole frames into the FAST→BRIEF→MATCH pipeline. It generates the frame-start pulse and raster counters, and throttles the source on FAST readiness and on the number of frames still in flight through MATCH. It sits between the sensor interface and the `CHIP` top-level inputs `i_pixel`/`i_depth`/`i_valid`/`i_frame_start`.

## Interface
Parameters:
- `WIDTH`, 640, pixels per line.
- `HEIGHT`, 480, lines per frame.
- `MAX_INFLIGHT`, 2, frames allowed between launch and MATCH `o_frame_end`; range 1..3.

Ports:
- `i_clk` in 1: single clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_enable` in 1: permits new frame launches.
- `s_valid` in 1: source pixel valid.
- `s_ready` out 1: source may transfer this cycle.
- `s_sof` in 1: marks first pixel of a frame.
- `s_pixel` in 8: grey pixel.
- `s_depth` in 10: depth sample.
- `i_chip_ready` in 1: FAST `o_ready`.
- `i_match_frame_end` in 1: MATCH `o_frame_end` pulse.
- `o_valid` out 1: pixel to CHIP.
- `o_frame_start` out 1: to CHIP `i_frame_start`.
- `o_pixel` out 8: pixel to CHIP.
- `o_depth` out 10: depth to CHIP.
- `o_x` out 10: column of current `o_pixel`.
- `o_y` out 10: row of current `o_pixel`.
- `o_inflight` out 2: frames in flight.
- `o_frame_cnt` out 16: frames launched, wraps at 65535→0.
- `o_err_sof` out 1: sticky protocol error.
- `o_busy` out 1: state ≠ IDLE or `o_inflight` ≠ 0.

## Operation
- A transfer happens when `s_valid & s_ready`.
- States and transitions:
  - IDLE: `s_ready`=0. Go to WAIT_SOF when `i_enable`=1.
  - WAIT_SOF: `s_ready` = `i_chip_ready & (inflight < MAX_INFLIGHT)`.
    - Transfer with `s_sof`=0: pixel dropped, not forwarded, `o_err_sof` set.
    - Transfer with `s_sof`=1: pixel forwarded as (0,0), `o_frame_start`=1, inflight+1, `o_frame_cnt`+1, go to STREAM.
  - STREAM: `s_ready` = `i_chip_ready`.
    - Each transfer is forwarded and advances x; at x=WIDTH-1, x→0 and y+1.
    - Transfer with `s_sof`=1 mid-frame: `o_err_sof` set, `s_sof` ignored, pixel forwarded normally.
    - Transfer of pixel (WIDTH-1, HEIGHT-1): go to WAIT_SOF if `i_enable`=1, else IDLE.
  - `i_enable` dropping during STREAM does not truncate the frame.
- inflight:
  - +1 on each launch; −1 on `i_match_frame_end`.
  - Launch and frame end in the same cycle: value unchanged.
  - `i_match_frame_end` at inflight=0 is ignored and sets `o_err_sof`.
- `o_err_sof` clears only on reset.
- x is 10 bits and y is 10 bits. Comparisons use WIDTH-1 and HEIGHT-1 truncated to 10 bits.

## Timing
- Reset value of every output is 0, including `s_ready`. The state resets to IDLE.
- `s_ready` is combinational from state, inflight and `i_chip_ready`. It does not depend on `s_valid`.
- `o_valid`, `o_frame_start`, `o_pixel`, `o_depth`, `o_x`, `o_y` are registered, with 1-cycle latency from the transfer.
- `o_valid`=0 in any cycle without a forwarded transfer.
- `o_frame_start` is high for exactly one cycle, coincident with `o_valid` for pixel (0,0).
- `o_inflight` and `o_frame_cnt` update on the clock edge after the launch or frame-end event.
- Asynchronous reset mid-frame returns to IDLE immediately with inflight=0. A partial frame is not completed; downstream is reset by the same `i_rst_n`.

## Structure
- A shared package `vo_pkg` holds:
  - the state enum `sched_state_e` {IDLE, WAIT_SOF, STREAM};
  - widths `PIX_W`=8, `DEPTH_W`=10, `COOR_W`=10.
- Sub-module `vo_raster_counter`: x/y counter with `inc`, `clr`, and last-pixel flag, parameterised by WIDTH and HEIGHT.

## Test plan
Benches use WIDTH=4, HEIGHT=2, MAX_INFLIGHT=2 unless stated.

- Nominal: enable, 8 transfers with `s_sof` on the first.
  - `o_frame_start` exactly once, with `o_x`,`o_y`=0,0.
  - Last output at 3,1; `o_frame_cnt`=1; `o_inflight`=1; state WAIT_SOF.
- Throttle: launch 2 frames with no `i_match_frame_end`.
  - `s_ready`=0 in WAIT_SOF while `o_inflight`=2.
  - One `i_match_frame_end` pulse makes `s_ready`=1 on the next cycle.
- Backpressure: `i_chip_ready`=0 for 5 cycles mid-frame.
  - `s_ready`=0 and `o_valid`=0 throughout; no pixel lost or duplicated; x/y sequence continuous.
- Protocol errors:
  - 2 transfers without `s_sof` in WAIT_SOF: both dropped, `o_err_sof`=1.
  - `s_sof` at pixel (2,0): forwarded as (2,0), no second `o_frame_start`.
- Simultaneous events and disable:
  - Launch in the same cycle as `i_match_frame_end` with inflight=1: `o_inflight` stays 1.
  - Deassert `i_enable` mid-frame: frame completes, then IDLE.
- Reset mid-frame at pixel (1,1): all outputs 0 asynchronously; restart yields `o_frame_cnt`=1 after the next frame.

Source files
------------

// File: rtl/vo_pkg.sv
// Shared types and widths for the visual-odometry front-end sequencer.
package vo_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned DEPTH_W = 10;
  localparam int unsigned COOR_W  = 10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    STREAM
  } sched_state_e;

  // Truncate a frame dimension to the coordinate width, minus one (last index).
  function automatic logic [COOR_W-1:0] last_index(input int unsigned dim);
    return COOR_W'(dim - 1);
  endfunction

endpackage

// File: rtl/vo_raster_counter.sv
// Raster x/y counter: holds the coordinate of the next pixel to be accepted.
module vo_raster_counter
  import vo_pkg::*;
#(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [COOR_W-1:0] x,
  output logic [COOR_W-1:0] y,
  output logic              last
);

  localparam logic [COOR_W-1:0] XLast = last_index(WIDTH);
  localparam logic [COOR_W-1:0] YLast = last_index(HEIGHT);

  logic [COOR_W-1:0] x_q, x_d;
  logic [COOR_W-1:0] y_q, y_d;

  // Next coordinate: advance along the line, wrap to the next line, wrap the frame.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (inc) begin
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Coordinate registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == XLast) && (y_q == YLast);

endmodule

// File: rtl/vo_frame_scheduler.sv
// Frame launcher: gates the camera stream into whole frames, tags raster position,
// and throttles on FAST readiness and on frames still in flight through MATCH.
module vo_frame_scheduler
  import vo_pkg::*;
#(
  parameter int unsigned WIDTH        = 640,
  parameter int unsigned HEIGHT       = 480,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_sof,
  input  logic [PIX_W-1:0]   s_pixel,
  input  logic [DEPTH_W-1:0] s_depth,
  input  logic               i_chip_ready,
  input  logic               i_match_frame_end,
  output logic               o_valid,
  output logic               o_frame_start,
  output logic [PIX_W-1:0]   o_pixel,
  output logic [DEPTH_W-1:0] o_depth,
  output logic [COOR_W-1:0]  o_x,
  output logic [COOR_W-1:0]  o_y,
  output logic [1:0]         o_inflight,
  output logic [15:0]        o_frame_cnt,
  output logic               o_err_sof,
  output logic               o_busy
);

  sched_state_e state_q, state_d;

  logic [1:0]         inflight_q, inflight_d;
  logic [15:0]        frame_cnt_q;
  logic               err_q;
  logic               valid_q, frame_start_q;
  logic [PIX_W-1:0]   pixel_q;
  logic [DEPTH_W-1:0] depth_q;
  logic [COOR_W-1:0]  x_out_q, y_out_q;

  logic              ready;
  logic              launch, fwd, sof_err, cnt_clr;
  logic              fe_dec, fe_err;
  logic [COOR_W-1:0] cur_x, cur_y;
  logic              cur_last;
  logic              room;

  assign room = 32'(inflight_q) < MAX_INFLIGHT;

  // Source handshake depends only on state, inflight and FAST readiness.
  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      WAIT_SOF: ready = i_chip_ready & room;
      STREAM:   ready = i_chip_ready;
      default:  ready = 1'b0;
    endcase
  end

  assign s_ready = ready;

  // Next state and per-transfer decisions.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    fwd     = 1'b0;
    sof_err = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (i_enable) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (s_valid && ready) begin
          if (s_sof) begin
            launch = 1'b1;
            fwd    = 1'b1;
            // A one-pixel frame is complete on its launch transfer.
            if (cur_last) state_d = i_enable ? WAIT_SOF : IDLE;
            else          state_d = STREAM;
          end else begin
            sof_err = 1'b1;
          end
        end
      end
      STREAM: begin
        if (s_valid && ready) begin
          fwd     = 1'b1;
          sof_err = s_sof;
          if (cur_last) state_d = i_enable ? WAIT_SOF : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame-end pulses with nothing in flight are protocol errors and are not counted.
  always_comb begin
    fe_dec     = i_match_frame_end && (inflight_q != 2'd0);
    fe_err     = i_match_frame_end && (inflight_q == 2'd0);
    inflight_d = inflight_q + 2'(launch) - 2'(fe_dec);
  end

  vo_raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (fwd),
    .clr   (cnt_clr),
    .x     (cur_x),
    .y     (cur_y),
    .last  (cur_last)
  );

  // State, bookkeeping and registered pixel output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      inflight_q    <= '0;
      frame_cnt_q   <= '0;
      err_q         <= 1'b0;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      pixel_q       <= '0;
      depth_q       <= '0;
      x_out_q       <= '0;
      y_out_q       <= '0;
    end else begin
      state_q       <= state_d;
      inflight_q    <= inflight_d;
      frame_cnt_q   <= frame_cnt_q + 16'(launch);
      err_q         <= err_q | sof_err | fe_err;
      valid_q       <= fwd;
      frame_start_q <= launch;
      if (fwd) begin
        pixel_q <= s_pixel;
        depth_q <= s_depth;
        x_out_q <= cur_x;
        y_out_q <= cur_y;
      end
    end
  end

  assign o_valid       = valid_q;
  assign o_frame_start = frame_start_q;
  assign o_pixel       = pixel_q;
  assign o_depth       = depth_q;
  assign o_x           = x_out_q;
  assign o_y           = y_out_q;
  assign o_inflight    = inflight_q;
  assign o_frame_cnt   = frame_cnt_q;
  assign o_err_sof     = err_q;
  assign o_busy        = (state_q != IDLE) || (inflight_q != 2'd0);

endmodule

// File: tb/tb_vo_frame_scheduler.sv
// Scoreboard bench for vo_frame_scheduler with a pixel-index reference model.
module tb_vo_frame_scheduler;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int MAXF = 2;
  localparam int MI   = 0;  // model: not accepting launches
  localparam int MW   = 1;  // model: waiting for start of frame
  localparam int MS   = 2;  // model: inside a frame

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, sv = 1'b0, ssof = 1'b0, cr = 1'b0, fe = 1'b0;
  logic [7:0] spix = '0;
  logic [9:0] sdep = '0;

  logic        s_ready, o_valid, o_frame_start, o_err_sof, o_busy;
  logic [7:0]  o_pixel;
  logic [9:0]  o_depth, o_x, o_y;
  logic [1:0]  o_inflight;
  logic [15:0] o_frame_cnt;

  vo_frame_scheduler #(
    .WIDTH        (W),
    .HEIGHT       (H),
    .MAX_INFLIGHT (MAXF)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_enable          (en),
    .s_valid           (sv),
    .s_ready           (s_ready),
    .s_sof             (ssof),
    .s_pixel           (spix),
    .s_depth           (sdep),
    .i_chip_ready      (cr),
    .i_match_frame_end (fe),
    .o_valid           (o_valid),
    .o_frame_start     (o_frame_start),
    .o_pixel           (o_pixel),
    .o_depth           (o_depth),
    .o_x               (o_x),
    .o_y               (o_y),
    .o_inflight        (o_inflight),
    .o_frame_cnt       (o_frame_cnt),
    .o_err_sof         (o_err_sof),
    .o_busy            (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] p;
    logic [9:0] d;
    int         x;
    int         y;
    bit         fs;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  int m_mode = MI;
  int m_idx = 0;
  int m_infl = 0;
  int m_fc = 0;
  bit m_err = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every forwarded pixel must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("pixel", int'(o_pixel), int'(e.p));
          check("depth", int'(o_depth), int'(e.d));
          check("x", int'(o_x), e.x);
          check("y", int'(o_y), e.y);
          check("frame_start", int'(o_frame_start), int'(e.fs));
        end
      end else begin
        check("frame_start_no_valid", int'(o_frame_start), 0);
      end
    end
  end

  // One clock of stimulus: check registered state, drive, check s_ready, advance model.
  task automatic step(input bit v, input bit sof, input bit rdy, input bit e, input bit f);
    bit   ready, xfer, launch, dec;
    exp_t t;
    @(negedge clk);
    check("inflight", int'(o_inflight), m_infl);
    check("frame_cnt", int'(o_frame_cnt), m_fc);
    check("err_sof", int'(o_err_sof), int'(m_err));
    check("busy", int'(o_busy), int'((m_mode != MI) || (m_infl != 0)));
    sv   = v;
    ssof = sof;
    cr   = rdy;
    en   = e;
    fe   = f;
    spix = 8'($urandom);
    sdep = 10'($urandom);
    #1;
    if (m_mode == MW)      ready = rdy && (m_infl < MAXF);
    else if (m_mode == MS) ready = rdy;
    else                   ready = 1'b0;
    check("s_ready", int'(s_ready), int'(ready));
    xfer   = v && ready;
    launch = 1'b0;
    t.p = spix;
    t.d = sdep;
    case (m_mode)
      MI: if (e) m_mode = MW;
      MW: if (xfer) begin
        if (sof) begin
          t.x = 0; t.y = 0; t.fs = 1'b1;
          q.push_back(t);
          launch = 1'b1;
          m_idx  = 1;
          m_mode = MS;
        end else begin
          m_err = 1'b1;
        end
      end
      default: if (xfer) begin
        t.x = m_idx % W; t.y = m_idx / W; t.fs = 1'b0;
        q.push_back(t);
        if (sof) m_err = 1'b1;
        m_idx++;
        if (m_idx == W * H) m_mode = e ? MW : MI;
      end
    endcase
    dec = f && (m_infl != 0);
    if (f && m_infl == 0) m_err = 1'b1;
    m_infl = m_infl + int'(launch) - int'(dec);
    m_fc   = (m_fc + int'(launch)) & 16'hFFFF;
  endtask

  // Run the source until the current or next frame completes; sof is well-formed
  // except at pixel index sof_bad.
  task automatic finish_frame(input int pv, input int pr, input bit e, input int sof_bad);
    bit seen = 1'b0;
    bit done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      bit sof;
      sof = (m_mode == MW) || (m_mode == MS && m_idx == sof_bad);
      step(($urandom_range(99) < pv), sof, ($urandom_range(99) < pr), e, 1'b0);
      if (m_mode == MS) seen = 1'b1;
      else if (seen)    done = 1'b1;
    end
    check("frame_timeout", int'(done), 1);
  endtask

  task automatic check_zero_outputs();
    check("rst_valid", int'(o_valid), 0);
    check("rst_frame_start", int'(o_frame_start), 0);
    check("rst_pixel", int'(o_pixel), 0);
    check("rst_depth", int'(o_depth), 0);
    check("rst_x", int'(o_x), 0);
    check("rst_y", int'(o_y), 0);
    check("rst_inflight", int'(o_inflight), 0);
    check("rst_frame_cnt", int'(o_frame_cnt), 0);
    check("rst_err_sof", int'(o_err_sof), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_s_ready", int'(s_ready), 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs();
    sv = 1'b0; ssof = 1'b0; fe = 1'b0; en = 1'b0;
    m_mode = MI; m_idx = 0; m_infl = 0; m_fc = 0; m_err = 1'b0;
    q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state, source already asserting valid.
    sv = 1'b1; cr = 1'b1; en = 1'b1;
    #12;
    check_zero_outputs();
    #5;
    rst_n = 1'b1;
    sv = 1'b0; en = 1'b0;

    // Nominal frame at full rate.
    step(0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    finish_frame(100, 100, 1, -1);
    step(0, 0, 1, 1, 0);

    // Throttle: second frame fills the pipe, launches blocked until a frame end.
    finish_frame(100, 100, 1, -1);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 1);

    // Backpressure mid-frame.
    step(1, 1, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0);
    finish_frame(100, 100, 1, -1);

    // Protocol errors: dropped pixels, then sof at (2,0).
    step(1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    finish_frame(100, 100, 1, 2);
    step(0, 0, 1, 1, 1);

    // Launch coincident with frame end at inflight=1.
    step(1, 1, 1, 1, 1);
    finish_frame(80, 80, 1, -1);

    // Disable mid-frame: frame completes, then idle.
    step(0, 0, 1, 1, 1);
    step(1, 1, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    finish_frame(100, 100, 0, -1);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);

    // Reset with pixel (1,1) next, then restart.
    step(0, 0, 1, 1, 1);
    step(1, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 0);
    async_reset();
    step(0, 0, 1, 1, 0);
    finish_frame(100, 100, 1, -1);
    step(0, 0, 1, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit sof;
      sof = (m_mode == MW) ? ($urandom_range(9) != 0) : ($urandom_range(29) == 0);
      step(($urandom_range(99) < 75), sof, ($urandom_range(99) < 80),
           ($urandom_range(19) != 0), ($urandom_range(99) < 6));
    end

    // Drain and make sure nothing expected is outstanding.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0);
    check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
